uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from two requesters into one shared UART transmitter.
// Define TX_ARB_WATCHDOG_EN to build the WAIT_BUSY/WAIT_DONE watchdog and the sticky err_timeout flag.
module uart_tx_arbiter #(
    parameter int DATA_W    = 8,
    parameter int WD_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    output logic [1:0]        grant,
    output logic              err_timeout,
    output logic [2:0]        state_dbg
);

    // Handshake: a requester holds reqN and dataN steady until it sees the one-cycle ackN pulse;
    // the arbiter samples requests only in IDLE, so a req still high afterwards is a new byte.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    state_t            state, state_nx;
    logic              last, last_nx;
    logic              ack0_nx, ack1_nx, tx_start_nx, pick1;
    logic [1:0]        grant_nx;
    logic [DATA_W-1:0] tx_data_nx;
    logic              wd_expired;

`ifdef TX_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    // wd_cnt is zero on the first WAIT_BUSY cycle, so cnt == WD_CYCLES-1 marks the WD_CYCLES-th wait cycle.
    assign wd_expired = ((state == S_WAIT_BUSY) || (state == S_WAIT_DONE)) &&
                        (wd_cnt == WD_W'(WD_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == S_START)
                wd_cnt <= '0;
            else if ((state == S_WAIT_BUSY) || (state == S_WAIT_DONE))
                wd_cnt <= wd_cnt + 1'b1;
            if (wd_expired)
                err_q <= 1'b1;
        end
    end

    assign err_timeout = err_q;
`else
    assign wd_expired  = 1'b0;
    // Constant 0: WD_CYCLES is never negative, it is referenced only so the parameter stays in use.
    assign err_timeout = (WD_CYCLES < 0);
`endif

    always_comb begin
        state_nx    = state;
        last_nx     = last;
        ack0_nx     = 1'b0;
        ack1_nx     = 1'b0;
        tx_start_nx = 1'b0;
        grant_nx    = grant;
        tx_data_nx  = tx_data;
        // last == 0 means requester 0 was served last, so requester 1 takes a tie.
        pick1       = req1 && (!req0 || !last);
        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_nx   = S_LOAD;
                    grant_nx   = pick1 ? 2'b10 : 2'b01;
                    tx_data_nx = pick1 ? data1 : data0;
                    ack0_nx    = !pick1;
                    ack1_nx    = pick1;
                    last_nx    = pick1;
                end
            end
            S_LOAD: begin
                if (!tx_busy) begin
                    state_nx    = S_START;
                    tx_start_nx = 1'b1;
                end
            end
            S_START:     state_nx = S_WAIT_BUSY;
            S_WAIT_BUSY: if (tx_busy) state_nx = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nx = S_IDLE;
                    grant_nx = 2'b00;
                end
            end
            default: begin
                state_nx = S_IDLE;
                grant_nx = 2'b00;
            end
        endcase
        if (wd_expired) begin
            state_nx = S_IDLE;
            grant_nx = 2'b00;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            last     <= 1'b1;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            tx_start <= 1'b0;
            grant    <= 2'b00;
            tx_data  <= '0;
        end else begin
            state    <= state_nx;
            last     <= last_nx;
            ack0     <= ack0_nx;
            ack1     <= ack1_nx;
            tx_start <= tx_start_nx;
            grant    <= grant_nx;
            tx_data  <= tx_data_nx;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: latency, round-robin order, LOAD stall, async reset, watchdog.
// Build with TX_ARB_WATCHDOG_EN defined to exercise the watchdog path instead of the wait-forever path.
module tb_uart_tx_arbiter;

    localparam int DATA_W = 8;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_START = 3'd2,
                           ST_WAIT_BUSY = 3'd3, ST_WAIT_DONE = 3'd4;

    logic              clock = 1'b0;
    logic              reset;
    logic              req0, req1, ack0, ack1, tx_start, tx_busy, err_timeout;
    logic [DATA_W-1:0] data0, data1, tx_data;
    logic [1:0]        grant;
    logic [2:0]        state_dbg;

    logic model_en, model_busy, force_busy;
    int   busy_left;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [1:0] exp_q[$];

    assign tx_busy = model_en ? model_busy : force_busy;

    uart_tx_arbiter #(.DATA_W(DATA_W), .WD_CYCLES(16)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant(grant), .err_timeout(err_timeout), .state_dbg(state_dbg)
    );

    // Clock / reset block
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "bench timed out");
    end

    // Transmitter model: busy for 10 cycles starting the cycle after tx_start.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            model_busy <= 1'b0;
            busy_left  <= 0;
        end else if (tx_start) begin
            model_busy <= 1'b1;
            busy_left  <= 10;
        end else if (busy_left > 1) begin
            busy_left <= busy_left - 1;
        end else if (busy_left == 1) begin
            busy_left  <= 0;
            model_busy <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives WAIT_BUSY -> WAIT_DONE -> IDLE from the first WAIT_BUSY cycle.
    task automatic finish_frame();
        force_busy = 1'b1;
        tick();
        force_busy = 1'b0;
        tick();
    endtask

    initial begin : stim
        int k, n_acks, mutex_bad, extra, k0, k1, starts;
        logic [1:0] exp_g;
        logic [7:0] exp_b;

        reset = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        model_en = 1'b0; force_busy = 1'b0;
        repeat (3) tick();
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_grant", grant, 2'b00);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_err", err_timeout, 0);
        check("rst_state", state_dbg, ST_IDLE);
        reset = 1'b1;
        repeat (2) tick();

        // Single request, minimum latency
        data0 = 8'hA5; req0 = 1'b1;
        tick();
        check("lat_ack0", ack0, 1);
        check("lat_ack1", ack1, 0);
        check("lat_grant", grant, 2'b01);
        check("lat_tx_data", tx_data, 8'hA5);
        check("lat_no_start_yet", tx_start, 0);
        req0 = 1'b0;
        tick();
        check("lat_tx_start", tx_start, 1);
        check("lat_ack_pulse", ack0, 0);
        check("lat_state_start", state_dbg, ST_START);
        tick();
        check("lat_start_pulse", tx_start, 0);
        check("lat_state_wait_busy", state_dbg, ST_WAIT_BUSY);
        force_busy = 1'b1;
        tick();
        check("lat_state_wait_done", state_dbg, ST_WAIT_DONE);
        check("lat_grant_held", grant, 2'b01);
        force_busy = 1'b0;
        tick();
        check("lat_state_idle", state_dbg, ST_IDLE);
        check("lat_grant_clear", grant, 2'b00);

        // Transmitter still busy when LOAD is entered
        force_busy = 1'b1; data1 = 8'h3C; req1 = 1'b1;
        tick();
        check("stall_ack1", ack1, 1);
        check("stall_grant", grant, 2'b10);
        check("stall_tx_data", tx_data, 8'h3C);
        req1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_no_start", tx_start, 0);
            check("stall_in_load", state_dbg, ST_LOAD);
        end
        force_busy = 1'b0;
        tick();
        check("stall_tx_start", tx_start, 1);
        tick();
        finish_frame();
        check("stall_back_idle", state_dbg, ST_IDLE);
        repeat (12) tick();

        // Both requesters held for 4 bytes each against the busy model
        model_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(2'b01);
            exp_q.push_back(2'b10);
        end
        data0 = 8'h10; data1 = 8'h20; req0 = 1'b1; req1 = 1'b1;
        n_acks = 0; mutex_bad = 0; k0 = 0; k1 = 0;
        for (int c = 0; c < 400 && n_acks < 8; c++) begin
            tick();
            if (ack0 && ack1) mutex_bad++;
            if (ack0 || ack1) begin
                n_acks++;
                if (exp_q.size() == 0) begin
                    check("rr_extra_ack", 1, 0);
                end else begin
                    exp_g = exp_q.pop_front();
                    exp_b = (exp_g == 2'b01) ? 8'h10 + 8'(k0) : 8'h20 + 8'(k1);
                    check("rr_grant", grant, exp_g);
                    check("rr_tx_data", tx_data, exp_b);
                end
                if (ack0) begin
                    k0++;
                    data0 = 8'h10 + 8'(k0);
                    if (k0 == 4) req0 = 1'b0;
                end
                if (ack1) begin
                    k1++;
                    data1 = 8'h20 + 8'(k1);
                    if (k1 == 4) req1 = 1'b0;
                end
            end
        end
        check("rr_ack_count", n_acks, 8);
        check("rr_mutex", mutex_bad, 0);
        extra = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (ack0 || ack1) extra++;
        end
        check("rr_no_extra_acks", extra, 0);
        check("rr_end_idle", state_dbg, ST_IDLE);
        model_en = 1'b0;

        // Reset asserted in WAIT_DONE
        data0 = 8'h5A; req0 = 1'b1;
        tick();
        check("rst_mid_ack0", ack0, 1);
        req0 = 1'b0;
        tick();
        tick();
        force_busy = 1'b1;
        tick();
        check("rst_mid_in_wait_done", state_dbg, ST_WAIT_DONE);
        #2 reset = 1'b0;
        #1;
        check("rst_async_grant", grant, 2'b00);
        check("rst_async_tx_data", tx_data, 8'h00);
        check("rst_async_state", state_dbg, ST_IDLE);
        check("rst_async_flags", {ack0, ack1, tx_start, err_timeout}, 4'b0000);
        force_busy = 1'b0;
        tick();
        reset = 1'b1;
        starts = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (tx_start || ack0 || ack1) starts++;
        end
        check("rst_no_start_after", starts, 0);

        // Pointer back at requester 1 after reset: requester 0 wins the tie
        data0 = 8'h11; data1 = 8'h22; req0 = 1'b1; req1 = 1'b1;
        tick();
        check("tie_after_rst_ack0", ack0, 1);
        check("tie_after_rst_ack1", ack1, 0);
        check("tie_after_rst_grant", grant, 2'b01);
        req0 = 1'b0;
        tick();
        tick();
        finish_frame();
        check("held_req_idle_grant", grant, 2'b00);
        tick();
        check("held_req_ack1", ack1, 1);
        check("held_req_tx_data", tx_data, 8'h22);
        req1 = 1'b0;
        tick();
        check("wd_tx_start", tx_start, 1);

        // Transmitter never goes busy after tx_start
`ifdef TX_ARB_WATCHDOG_EN
        k = 0;
        while (k < 20 && !err_timeout) begin
            tick();
            k++;
        end
        check("wd_within_17", (k >= 1 && k <= 17), 1);
        check("wd_err_set", err_timeout, 1);
        check("wd_grant_clear", grant, 2'b00);
        check("wd_state_idle", state_dbg, ST_IDLE);
        data0 = 8'h77; req0 = 1'b1;
        tick();
        check("wd_next_ack0", ack0, 1);
        req0 = 1'b0;
        tick();
        tick();
        finish_frame();
        check("wd_sticky", err_timeout, 1);
        check("wd_next_idle", state_dbg, ST_IDLE);
`else
        k = 0;
        repeat (40) tick();
        check("nowd_err_zero", err_timeout, 0);
        check("nowd_still_waiting", state_dbg, ST_WAIT_BUSY);
        check("nowd_grant_held", grant, 2'b10);
        finish_frame();
        check("nowd_back_idle", state_dbg, ST_IDLE);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
